sweep_counter_ctrl: RTL

- FSM sequencer for an external N-bit up/down counter with en/up/syn_clr/load/d inputs and a q output.
- Produces a triangular sweep lo→hi→lo with a programmable step period, a programmable dwell at each extreme, and a programmable number of cycles.
- Sits between the simulator register bank (start/abort/config) and the ramp counter that feeds the dummy DAC path.

---
 rtl/sweep_counter_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/sweep_counter_ctrl.sv
// sweep_counter_ctrl
//   Sequencer for an external N-bit up/down counter. Produces a triangular
//   sweep lo -> hi -> lo with a programmable step period (presc+1 clocks per
//   step), a dwell of hold+1 clocks at each extreme, and ncyc triangles
//   (ncyc = 0 runs until abort).
//
//   Optional feature: define SWEEP_SAWTOOTH_EN to enable the sawtooth mode
//   selected by saw. In sawtooth mode DWELL_HI reloads lo instead of ramping
//   down. Without the macro the saw port is ignored.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   start             one-cycle request, sampled only in IDLE
//   abort             synchronous stop, any state
//   lo, hi            sweep bounds (N bits)
//   presc, hold       step prescaler and dwell length (PRESC_W bits)
//   ncyc              number of triangles, 0 = continuous (NCYC_W bits)
//   saw               sawtooth select (only with SWEEP_SAWTOOTH_EN)
//   cnt_q             counter value
//   cnt_en/up/clr/load, cnt_d   counter controls and load value
//   busy              not in IDLE
//   done              one-cycle pulse on normal completion
//   err               sticky configuration error (lo >= hi at start)
//   cyc_count         completed triangles (saturating)
module sweep_counter_ctrl #(
  parameter int N       = 14,
  parameter int PRESC_W = 16,
  parameter int NCYC_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [N-1:0]       lo,
  input  logic [N-1:0]       hi,
  input  logic [PRESC_W-1:0] presc,
  input  logic [PRESC_W-1:0] hold,
  input  logic [NCYC_W-1:0]  ncyc,
  input  logic               saw,
  input  logic [N-1:0]       cnt_q,
  output logic               cnt_en,
  output logic               cnt_up,
  output logic               cnt_clr,
  output logic               cnt_load,
  output logic [N-1:0]       cnt_d,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [NCYC_W-1:0]  cyc_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RAMP_UP, S_DWELL_HI, S_RAMP_DN, S_DWELL_LO
  } state_t;

  state_t             r_state;
  logic [N-1:0]       r_lo, r_hi, r_cnt_d;
  logic [PRESC_W-1:0] r_presc, r_hold, r_pc;
  logic [NCYC_W-1:0]  r_ncyc, r_cyc;
  logic               r_cnt_en, r_cnt_up, r_cnt_clr, r_cnt_load, r_done, r_err;
`ifdef SWEEP_SAWTOOTH_EN
  logic               r_saw;
`else
  logic               w_unused_saw;
  assign w_unused_saw = saw;
`endif

  logic [PRESC_W-1:0] w_pc_inc;
  logic               w_pc_hit, w_dwell_hit, w_first_en, w_up_hit, w_dn_hit, w_last;
  logic [NCYC_W-1:0]  w_cyc_inc;

  // r_pc is the prescaler in ramp states and the dwell counter in dwell states.
  // cnt_en is registered, so the strobe for the next cycle is predicted from
  // the next value of r_pc rather than decoded from the current one.
  assign w_pc_inc    = r_pc + PRESC_W'(1);
  assign w_pc_hit    = (r_pc == r_presc);
  assign w_dwell_hit = (r_pc == r_hold);
  assign w_first_en  = (r_presc == '0);
  // N+1-bit compares so hi = 2^N-1 and lo = 0 do not wrap.
  assign w_up_hit    = (({1'b0, cnt_q} + (N+1)'(1)) == {1'b0, r_hi});
  assign w_dn_hit    = (({1'b0, cnt_q} - (N+1)'(1)) == {1'b0, r_lo});
  assign w_cyc_inc   = (&r_cyc) ? r_cyc : (r_cyc + NCYC_W'(1));
  assign w_last      = (r_ncyc != '0) && (w_cyc_inc == r_ncyc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_lo       <= '0;
      r_hi       <= '0;
      r_cnt_d    <= '0;
      r_presc    <= '0;
      r_hold     <= '0;
      r_pc       <= '0;
      r_ncyc     <= '0;
      r_cyc      <= '0;
      r_cnt_en   <= 1'b0;
      r_cnt_up   <= 1'b0;
      r_cnt_clr  <= 1'b0;
      r_cnt_load <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef SWEEP_SAWTOOTH_EN
      r_saw      <= 1'b0;
`endif
    end else begin
      r_cnt_en   <= 1'b0;
      r_cnt_clr  <= 1'b0;
      r_cnt_load <= 1'b0;
      r_done     <= 1'b0;
      // Abort overrides any strobe that would have been registered this edge.
      if (abort && (r_state != S_IDLE)) begin
        r_state   <= S_IDLE;
        r_cnt_clr <= 1'b1;
        r_pc      <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !abort) begin
              if (lo >= hi) begin
                r_err <= 1'b1;
              end else begin
                r_lo       <= lo;
                r_hi       <= hi;
                r_presc    <= presc;
                r_hold     <= hold;
                r_ncyc     <= ncyc;
`ifdef SWEEP_SAWTOOTH_EN
                r_saw      <= saw;
`endif
                r_err      <= 1'b0;
                r_cyc      <= '0;
                r_cnt_d    <= lo;
                r_cnt_load <= 1'b1;
                r_state    <= S_LOAD;
              end
            end
          end
          S_LOAD: begin
            r_state  <= S_RAMP_UP;
            r_cnt_up <= 1'b1;
            r_pc     <= '0;
            r_cnt_en <= w_first_en;
          end
          S_RAMP_UP: begin
            if (w_pc_hit) begin
              r_pc <= '0;
              if (w_up_hit) r_state <= S_DWELL_HI;
              else          r_cnt_en <= w_first_en;
            end else begin
              r_pc     <= w_pc_inc;
              r_cnt_en <= (w_pc_inc == r_presc);
            end
          end
          S_DWELL_HI: begin
            if (w_dwell_hit) begin
              r_pc <= '0;
`ifdef SWEEP_SAWTOOTH_EN
              if (r_saw) begin
                r_cyc <= w_cyc_inc;
                if (w_last) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
                end else begin
                  r_state    <= S_LOAD;
                  r_cnt_load <= 1'b1;
                end
              end else
`endif
              begin
                r_state  <= S_RAMP_DN;
                r_cnt_up <= 1'b0;
                r_cnt_en <= w_first_en;
              end
            end else begin
              r_pc <= w_pc_inc;
            end
          end
          S_RAMP_DN: begin
            if (w_pc_hit) begin
              r_pc <= '0;
              if (w_dn_hit) r_state <= S_DWELL_LO;
              else          r_cnt_en <= w_first_en;
            end else begin
              r_pc     <= w_pc_inc;
              r_cnt_en <= (w_pc_inc == r_presc);
            end
          end
          S_DWELL_LO: begin
            if (w_dwell_hit) begin
              r_pc  <= '0;
              r_cyc <= w_cyc_inc;
              if (w_last) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end else begin
                r_state  <= S_RAMP_UP;
                r_cnt_up <= 1'b1;
                r_cnt_en <= w_first_en;
              end
            end else begin
              r_pc <= w_pc_inc;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign cnt_en    = r_cnt_en;
  assign cnt_up    = r_cnt_up;
  assign cnt_clr   = r_cnt_clr;
  assign cnt_load  = r_cnt_load;
  assign cnt_d     = r_cnt_d;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign cyc_count = r_cyc;

endmodule
